// File: rtl/y86_pkg.sv
// Shared types and constants for the sequential Y86-64 stage sequencer.
// Holds the sequencer states, status codes, instruction codes and the memory-use decode.
package y86_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEMORY,
    S_WRITEBACK,
    S_PC_UPD,
    S_HALT
  } state_e;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  // Instructions that touch data memory; all others skip the MEMORY stage.
  function automatic logic uses_mem(input logic [3:0] icode);
    return icode inside {I_RMMOVQ, I_MRMOVQ, I_CALL, I_RET, I_PUSHQ, I_POPQ};
  endfunction

endpackage

// File: rtl/y86_mem_wait.sv
// Counts cycles spent in MEMORY and flags the last permitted cycle before timeout.
// The count is forced to zero whenever the sequencer is outside MEMORY.
module y86_mem_wait #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active_i,
  output logic timeout_o
);

  localparam int unsigned W = $clog2(MEM_TIMEOUT + 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = active_i ? cnt_q + W'(1) : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // cnt_q holds completed wait cycles, so this is the MEM_TIMEOUT-th MEMORY cycle.
  assign timeout_o = active_i && (cnt_q == W'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/y86_seq_ctrl.sv
// Multi-cycle stage sequencer for the sequential Y86-64 core: one-hot stage enables,
// data-memory wait with timeout, architectural status latch and cycle/retire counters.
module y86_seq_ctrl
  import y86_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [3:0]       icode_i,
  input  logic [2:0]       stat_i,
  input  logic             mem_ready_i,
  input  logic             dmem_error_i,
  output logic             fetch_en_o,
  output logic             decode_en_o,
  output logic             exec_en_o,
  output logic             cc_en_o,
  output logic             mem_en_o,
  output logic             wb_en_o,
  output logic             pc_en_o,
  output logic [2:0]       stat_o,
  output logic             halted_o,
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic [CNT_W-1:0] instr_cnt_o
);

  state_e           state_q, state_d;
  logic [2:0]       stat_q, stat_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] instr_q, instr_d;
  logic             mem_timeout;

  y86_mem_wait #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_mem_wait (
    .clk      (clk),
    .rst_n    (rst_n),
    .active_i (state_q == S_MEMORY),
    .timeout_o(mem_timeout)
  );

  always_comb begin
    state_d     = state_q;
    stat_d      = stat_q;
    cycle_d     = cycle_q;
    instr_d     = instr_q;
    fetch_en_o  = 1'b0;
    decode_en_o = 1'b0;
    exec_en_o   = 1'b0;
    cc_en_o     = 1'b0;
    mem_en_o    = 1'b0;
    wb_en_o     = 1'b0;
    pc_en_o     = 1'b0;

    if (state_q != S_IDLE && state_q != S_HALT) cycle_d = cycle_q + CNT_W'(1);

    case (state_q)
      S_IDLE: if (start_i) state_d = S_FETCH;
      S_FETCH: begin
        fetch_en_o = 1'b1;
        state_d    = S_DECODE;
      end
      S_DECODE: begin
        decode_en_o = 1'b1;
        if (stat_i != STAT_AOK) begin
          stat_d  = stat_i;
          state_d = S_HALT;
        end else begin
          state_d = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        exec_en_o = 1'b1;
        cc_en_o   = (icode_i == I_OPQ);
        state_d   = uses_mem(icode_i) ? S_MEMORY : S_WRITEBACK;
      end
      S_MEMORY: begin
        mem_en_o = 1'b1;
        // Ready wins over a simultaneous timeout.
        if (mem_ready_i) begin
          if (dmem_error_i) begin
            stat_d  = STAT_ADR;
            state_d = S_HALT;
          end else begin
            state_d = S_WRITEBACK;
          end
        end else if (mem_timeout) begin
          stat_d  = STAT_ADR;
          state_d = S_HALT;
        end
      end
      S_WRITEBACK: begin
        wb_en_o = 1'b1;
        state_d = S_PC_UPD;
      end
      S_PC_UPD: begin
        pc_en_o = 1'b1;
        instr_d = instr_q + CNT_W'(1);
        state_d = S_FETCH;
      end
      default: state_d = S_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      stat_q  <= STAT_AOK;
      cycle_q <= '0;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      stat_q  <= stat_d;
      cycle_q <= cycle_d;
      instr_q <= instr_d;
    end
  end

  assign stat_o      = stat_q;
  assign halted_o    = (state_q == S_HALT);
  assign cycle_cnt_o = cycle_q;
  assign instr_cnt_o = instr_q;

endmodule

// File: tb/tb_y86_seq_ctrl.sv
// Scoreboard bench for y86_seq_ctrl: stimulus queues the expected per-cycle response,
// a negedge monitor pops and compares whenever a stage enable or halted_o is visible.
module tb_y86_seq_ctrl;

  localparam logic [6:0] EF = 7'b1000000;
  localparam logic [6:0] ED = 7'b0100000;
  localparam logic [6:0] EE = 7'b0010000;
  localparam logic [6:0] EC = 7'b0011000;
  localparam logic [6:0] EM = 7'b0000100;
  localparam logic [6:0] EW = 7'b0000010;
  localparam logic [6:0] EP = 7'b0000001;
  localparam logic [6:0] E0 = 7'b0000000;

  typedef struct packed {
    logic [6:0] en;
    logic [2:0] stat;
    logic       halted;
    logic [3:0] icnt;
    logic [3:0] ccnt;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_i = 1'b0;
  logic [3:0] icode_i = 4'h0;
  logic [2:0] stat_i = 3'd1;
  logic       mem_ready_i = 1'b0;
  logic       dmem_error_i = 1'b0;
  logic       fetch_en_o, decode_en_o, exec_en_o, cc_en_o, mem_en_o, wb_en_o, pc_en_o;
  logic [2:0] stat_o;
  logic       halted_o;
  logic [3:0] cycle_cnt_o, instr_cnt_o;
  logic [6:0] en_vec;

  exp_t       q[$];
  int         checks = 0;
  int         errors = 0;
  bit         mon_on = 1'b0;
  logic [2:0] exp_stat = 3'd1;
  logic [3:0] exp_icnt = 4'd0;
  logic [3:0] exp_ccnt = 4'd0;

  y86_seq_ctrl #(
    .MEM_TIMEOUT(15),
    .CNT_W      (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .icode_i     (icode_i),
    .stat_i      (stat_i),
    .mem_ready_i (mem_ready_i),
    .dmem_error_i(dmem_error_i),
    .fetch_en_o  (fetch_en_o),
    .decode_en_o (decode_en_o),
    .exec_en_o   (exec_en_o),
    .cc_en_o     (cc_en_o),
    .mem_en_o    (mem_en_o),
    .wb_en_o     (wb_en_o),
    .pc_en_o     (pc_en_o),
    .stat_o      (stat_o),
    .halted_o    (halted_o),
    .cycle_cnt_o (cycle_cnt_o),
    .instr_cnt_o (instr_cnt_o)
  );

  assign en_vec = {fetch_en_o, decode_en_o, exec_en_o, cc_en_o, mem_en_o, wb_en_o, pc_en_o};

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mon_on && ((|en_vec) || halted_o === 1'b1)) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got en=%b halted=%b expected no activity at %0t",
                 en_vec, halted_o, $time);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("enables", 32'(en_vec), 32'(e.en));
        chk("stat_o", 32'(stat_o), 32'(e.stat));
        chk("halted_o", 32'(halted_o), 32'(e.halted));
        chk("instr_cnt_o", 32'(instr_cnt_o), 32'(e.icnt));
        chk("cycle_cnt_o", 32'(cycle_cnt_o), 32'(e.ccnt));
        $display("cycle en=%b stat=%0d halted=%b icnt=%0d ccnt=%0d", en_vec, stat_o,
                 halted_o, instr_cnt_o, cycle_cnt_o);
      end
    end
  end

  // One sequencer cycle: queue what this cycle must show, then advance the clock.
  task automatic step(input logic [6:0] en, input logic rdy, input logic err);
    mem_ready_i  = rdy;
    dmem_error_i = err;
    q.push_back('{en, exp_stat, (en == E0), exp_icnt, exp_ccnt});
    @(posedge clk); #1;
    mem_ready_i  = 1'b0;
    dmem_error_i = 1'b0;
    if (en != E0) exp_ccnt = exp_ccnt + 4'd1;
    if (en == EP) exp_icnt = exp_icnt + 4'd1;
  endtask

  task automatic front(input logic [3:0] ic, input logic [2:0] st);
    icode_i = ic;
    stat_i  = st;
    step(EF, 1'b0, 1'b0);
    step(ED, 1'b0, 1'b0);
  endtask

  task automatic back();
    step(EW, 1'b0, 1'b0);
    step(EP, 1'b0, 1'b0);
  endtask

  task automatic start_run();
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic do_reset(input bit active, input logic [6:0] cur_en);
    rst_n = 1'b0;
    if (active) step(cur_en, 1'b0, 1'b0);
    else begin
      @(posedge clk); #1;
    end
    rst_n    = 1'b1;
    exp_stat = 3'd1;
    exp_icnt = 4'd0;
    exp_ccnt = 4'd0;
    chk("rst_enables", 32'(en_vec), 32'(0));
    chk("rst_stat", 32'(stat_o), 32'(1));
    chk("rst_halted", 32'(halted_o), 32'(0));
    chk("rst_instr_cnt", 32'(instr_cnt_o), 32'(0));
    chk("rst_cycle_cnt", 32'(cycle_cnt_o), 32'(0));
    $display("reset stat=%0d halted=%b icnt=%0d ccnt=%0d", stat_o, halted_o, instr_cnt_o,
             cycle_cnt_o);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    do_reset(1'b0, E0);
    mon_on = 1'b1;

    // irmovq, OPq, mrmovq (ready on 3rd wait cycle), then halt at decode
    start_run();
    front(4'h3, 3'd1); step(EE, 1'b0, 1'b0); back();
    front(4'h6, 3'd1); step(EC, 1'b0, 1'b0); back();
    front(4'h5, 3'd1); step(EE, 1'b0, 1'b0);
    step(EM, 1'b0, 1'b0); step(EM, 1'b0, 1'b0); step(EM, 1'b1, 1'b0);
    back();
    front(4'h0, 3'd2);
    exp_stat = 3'd2;
    start_i = 1'b1;
    repeat (3) step(E0, 1'b0, 1'b0);
    start_i = 1'b0;
    do_reset(1'b1, E0);

    // rmmovq with mem_ready_i never arriving: timeout after 15 wait cycles
    start_run();
    front(4'h4, 3'd1); step(EE, 1'b0, 1'b0);
    repeat (15) step(EM, 1'b0, 1'b0);
    exp_stat = 3'd3;
    repeat (2) step(E0, 1'b0, 1'b0);
    do_reset(1'b1, E0);

    // mrmovq with ready+error on the 2nd wait cycle
    start_run();
    front(4'h5, 3'd1); step(EE, 1'b0, 1'b0);
    step(EM, 1'b0, 1'b0); step(EM, 1'b1, 1'b1);
    exp_stat = 3'd3;
    step(E0, 1'b0, 1'b0);
    do_reset(1'b1, E0);

    // invalid instruction at decode
    start_run();
    front(4'hF, 3'd4);
    exp_stat = 3'd4;
    repeat (2) step(E0, 1'b0, 1'b0);
    do_reset(1'b1, E0);

    // reset in the middle of a memory wait
    start_run();
    front(4'h5, 3'd1); step(EE, 1'b0, 1'b0);
    step(EM, 1'b0, 1'b0); step(EM, 1'b0, 1'b0);
    do_reset(1'b1, EM);

    // 16 irmovq: 4-bit counters wrap with the sequence undisturbed
    start_run();
    for (int i = 0; i < 16; i++) begin
      front(4'h3, 3'd1); step(EE, 1'b0, 1'b0); back();
    end
    step(EF, 1'b0, 1'b0);
    do_reset(1'b1, ED);

    repeat (2) @(posedge clk);
    chk("scoreboard_drained", 32'(q.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
